// File: rtl/ysyx_22041752_mem_arb.sv
// Shares one single-beat 64-bit memory port between the ICACHE and DCACHE miss engines.
// Round-robin between lines, line-locked between beats, with a sticky hang watchdog.
module ysyx_22041752_mem_arb #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 64,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req,
   input  logic [ADDR_WD-1:0] i_addr,
   output logic               i_ready,
   output logic               i_valid,
   input  logic               d_req,
   input  logic               d_wen,
   input  logic [ADDR_WD-1:0] d_addr,
   input  logic [DATA_WD-1:0] d_wdata,
   output logic               d_ready,
   output logic               d_valid,
   output logic [DATA_WD-1:0] rdata,
   output logic               mem_req,
   output logic               mem_wen,
   output logic [ADDR_WD-1:0] mem_addr,
   output logic [DATA_WD-1:0] mem_wdata,
   input  logic               mem_ready,
   input  logic [DATA_WD-1:0] mem_rdata,
   input  logic               mem_valid,
   output logic               err,
   output logic [2:0]         o_dbg_state
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   // IDLE is encoded as 0 so the debug port reads 0 after reset.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ_I  = 3'd1,
      S_REQ_D  = 3'd2,
      S_RESP_I = 3'd3,
      S_RESP_D = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_prio;
   logic              r_lock_v;
   logic              r_lock_d;
   logic [WD_W-1:0]   r_wd;
   logic              r_err;
   logic              r_mem_req;
   logic              r_mem_wen;
   logic [ADDR_WD-1:0] r_mem_addr;
   logic [DATA_WD-1:0] r_mem_wdata;

   logic w_grant_i;
   logic w_grant_d;
   logic w_i_ready;
   logic w_d_ready;
   logic w_i_valid;
   logic w_d_valid;
   logic w_accept;
   logic w_done;
   logic w_done_d;

   // Handshake: x_req is held until x_ready; x_ready pulses with mem_ready while in
   // REQ_x, x_valid pulses with mem_valid while in REQ_x or RESP_x; both are 1-cycle.
   always_comb begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      if (r_state == S_IDLE) begin
         if (r_lock_v) begin
            w_grant_d = r_lock_d & d_req;
            w_grant_i = ~r_lock_d & i_req;
         end else if (i_req && d_req) begin
            w_grant_d = r_prio;
            w_grant_i = ~r_prio;
         end else begin
            w_grant_i = i_req;
            w_grant_d = d_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_i_ready   = 1'b0;
      w_d_ready   = 1'b0;
      w_i_valid   = 1'b0;
      w_d_valid   = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_done_d    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant_i) begin
               w_state_nxt = S_REQ_I;
            end else if (w_grant_d) begin
               w_state_nxt = S_REQ_D;
            end
         end
         S_REQ_I: begin
            if (mem_ready) begin
               w_i_ready = 1'b1;
               w_accept  = 1'b1;
               if (mem_valid) begin
                  w_i_valid   = 1'b1;
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_RESP_I;
               end
            end
         end
         S_REQ_D: begin
            if (mem_ready) begin
               w_d_ready = 1'b1;
               w_accept  = 1'b1;
               if (mem_valid) begin
                  w_d_valid   = 1'b1;
                  w_done      = 1'b1;
                  w_done_d    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_RESP_D;
               end
            end
         end
         S_RESP_I: begin
            if (mem_valid) begin
               w_i_valid   = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_RESP_D: begin
            if (mem_valid) begin
               w_d_valid   = 1'b1;
               w_done      = 1'b1;
               w_done_d    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The request is captured at grant so the memory side sees stable registered values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_wen   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_grant_i) begin
         r_mem_req   <= 1'b1;
         r_mem_wen   <= 1'b0;
         r_mem_addr  <= i_addr;
         r_mem_wdata <= '0;
      end else if (w_grant_d) begin
         r_mem_req   <= 1'b1;
         r_mem_wen   <= d_wen;
         r_mem_addr  <= d_addr;
         r_mem_wdata <= d_wdata;
      end else if (w_accept) begin
         r_mem_req   <= 1'b0;
      end
   end

   // First beat of a line locks the port to its owner; the second beat hands priority over.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio   <= 1'b0;
         r_lock_v <= 1'b0;
         r_lock_d <= 1'b0;
      end else if (w_done) begin
         if (!r_mem_addr[3]) begin
            r_lock_v <= 1'b1;
            r_lock_d <= w_done_d;
         end else begin
            r_lock_v <= 1'b0;
            r_prio   <= ~w_done_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_state_nxt != r_state) begin
            r_wd <= '0;
         end else if (r_state != S_IDLE && r_wd != WD_MAX) begin
            r_wd <= r_wd + 1'b1;
         end
         if (r_wd == WD_MAX) begin
            r_err <= 1'b1;
         end
      end
   end

   assign i_ready     = w_i_ready & ~reset;
   assign i_valid     = w_i_valid & ~reset;
   assign d_ready     = w_d_ready & ~reset;
   assign d_valid     = w_d_valid & ~reset;
   assign rdata       = mem_rdata;
   assign mem_req     = r_mem_req;
   assign mem_wen     = r_mem_wen;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign err         = r_err;
   assign o_dbg_state = r_state;

endmodule
